// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath: default widths, accumulator
// state encoding and the operand sign/zero-extension helper.
package nn_pkg;

   // Default widths shared with the rest of the network
   localparam int NN_IN_W  = 18;
   localparam int NN_OUT_W = 24;

   // Widest operand the extension helper supports
   localparam int EXT_MAX_W = 64;

   // Accumulator state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      ACC  = ST_ACC,
      OUT  = ST_OUT
   } state_t;

   // Extend the low in_w bits of raw to EXT_MAX_W bits, replicating the
   // operand sign bit when is_signed is set and filling with zeros otherwise.
   function automatic logic [EXT_MAX_W-1:0] ext_operand(
      input logic [EXT_MAX_W-1:0] raw,
      input int                   in_w,
      input bit                   is_signed
   );
      logic [EXT_MAX_W-1:0] keep;
      logic [EXT_MAX_W-1:0] low;
      logic                 fill;
      keep = (EXT_MAX_W'(1) << in_w) - EXT_MAX_W'(1);
      low  = raw & keep;
      fill = is_signed && ((low & ~(keep >> 1)) != '0);
      return fill ? (low | ~keep) : low;
   endfunction

endpackage

// File: rtl/nn_sat_adder.sv
// Combinational W-bit adder with overflow flag. With NN_ACCUM_SATURATE_EN
// defined the result clamps to the representable extreme on overflow;
// otherwise it wraps modulo 2^W.
module nn_sat_adder
   import nn_pkg::*;
#(
   parameter int W      = NN_OUT_W,
   parameter int SIGNED = 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);

   logic [W:0] raw;

   assign raw = {1'b0, a} + {1'b0, b};

   // Overflow rule depends on operand interpretation
   generate
      if (SIGNED != 0) begin : g_ovf_signed
         assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
      end else begin : g_ovf_unsigned
         assign ovf = raw[W];
      end
   endgenerate

`ifdef NN_ACCUM_SATURATE_EN
   logic [W-1:0] clamp;

   // On signed overflow both operands share a sign, so a's sign picks the rail
   generate
      if (SIGNED != 0) begin : g_clamp_signed
         assign clamp = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin : g_clamp_unsigned
         assign clamp = {W{1'b1}};
      end
   endgenerate

   assign sum = ovf ? clamp : raw[W-1:0];
`else
   assign sum = raw[W-1:0];
`endif

endmodule

// File: rtl/nn_stream_accum.sv
// Streaming packet accumulator: sums IN_W-bit operand beats into one OUT_W-bit
// result per packet, reporting beat count, sticky overflow and forced close.
// Optional build macro: NN_ACCUM_SATURATE_EN (clamp instead of wrap).
module nn_stream_accum
   import nn_pkg::*;
#(
   parameter int IN_W      = NN_IN_W,
   parameter int OUT_W     = NN_OUT_W,
   parameter int MAX_TERMS = 64,
   parameter int SIGNED    = 1,
   localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf,
   output logic             out_forced
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

   // Reject configurations the datapath cannot represent
   generate
      if (OUT_W < IN_W + 1) begin : g_bad_out_w
         $error("nn_stream_accum: OUT_W must be at least IN_W+1");
      end
      if (OUT_W > EXT_MAX_W) begin : g_too_wide
         $error("nn_stream_accum: OUT_W exceeds the extension helper width");
      end
      if (MAX_TERMS < 1) begin : g_bad_terms
         $error("nn_stream_accum: MAX_TERMS must be at least 1");
      end
   endgenerate

   state_t           state, state_next;
   logic [OUT_W-1:0] sum_reg, sum_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             ovf_reg, ovf_next;
   logic             forced_reg, forced_next;

   logic [EXT_MAX_W-1:0] ext_full;
   logic [OUT_W-1:0]     operand;
   logic [OUT_W-1:0]     add_sum;
   logic                 add_ovf;
   logic [CNT_W-1:0]     cnt_inc;

   assign ext_full = ext_operand({{(EXT_MAX_W-IN_W){1'b0}}, in_data}, IN_W, SIGNED != 0);
   assign operand  = ext_full[OUT_W-1:0];
   assign cnt_inc  = cnt_reg + CNT_W'(1);

   nn_sat_adder #(
      .W      (OUT_W),
      .SIGNED (SIGNED)
   ) u_adder (
      .a   (sum_reg),
      .b   (operand),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   // State and packet registers; reset discards any partial packet
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sum_reg    <= '0;
         cnt_reg    <= '0;
         ovf_reg    <= 1'b0;
         forced_reg <= 1'b0;
      end else begin
         state      <= state_next;
         sum_reg    <= sum_next;
         cnt_reg    <= cnt_next;
         ovf_reg    <= ovf_next;
         forced_reg <= forced_next;
      end
   end

   // Next-state and packet update; in IDLE/ACC a transfer is just in_valid
   always_comb begin
      state_next  = state;
      sum_next    = sum_reg;
      cnt_next    = cnt_reg;
      ovf_next    = ovf_reg;
      forced_next = forced_reg;
      case (state)
         IDLE: begin
            if (in_valid) begin
               sum_next    = operand;
               cnt_next    = CNT_W'(1);
               ovf_next    = 1'b0;
               forced_next = 1'b0;
               if (in_last || (MAX_TERMS == 1)) begin
                  state_next  = OUT;
                  forced_next = !in_last;
               end else begin
                  state_next = ACC;
               end
            end
         end
         ACC: begin
            if (in_valid) begin
               sum_next = add_sum;
               cnt_next = cnt_inc;
               ovf_next = ovf_reg | add_ovf;
               if (in_last) begin
                  state_next = OUT;
               end else if (cnt_inc == MAX_CNT) begin
                  state_next  = OUT;
                  forced_next = 1'b1;
               end
            end
         end
         OUT: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // in_ready is held low while reset is asserted so every output reads 0
   assign in_ready   = (state != OUT) && !rst;
   assign out_valid  = (state == OUT);
   assign out_data   = sum_reg;
   assign out_count  = cnt_reg;
   assign out_ovf    = ovf_reg;
   assign out_forced = forced_reg;

endmodule

// File: tb/tb_nn_stream_accum.sv
// Self-checking bench for nn_stream_accum: three instances (default,
// OUT_W=20, MAX_TERMS=4) driven by directed steps, results checked through
// an expected-result queue.
module tb_nn_stream_accum;

   typedef struct {
      int          id;
      logic [23:0] data;
      logic [6:0]  cnt;
      logic        ovf;
      logic        forced;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid  [3];
   logic        in_last   [3];
   logic        out_ready [3];
   logic [17:0] in_data   [3];
   logic        rdy [3];
   logic        ov  [3];
   logic        ovf [3];
   logic        frc [3];
   logic [23:0] od  [3];
   logic [6:0]  oc  [3];

   logic [23:0] a_data, c_data;
   logic [19:0] b_data;
   logic [6:0]  a_cnt, b_cnt;
   logic [2:0]  c_cnt;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   nn_stream_accum #(.IN_W(18), .OUT_W(24), .MAX_TERMS(64), .SIGNED(1)) u_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(rdy[0]), .in_data(in_data[0]), .in_last(in_last[0]),
      .out_valid(ov[0]), .out_ready(out_ready[0]), .out_data(a_data), .out_count(a_cnt),
      .out_ovf(ovf[0]), .out_forced(frc[0])
   );

   nn_stream_accum #(.IN_W(18), .OUT_W(20), .MAX_TERMS(64), .SIGNED(1)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(rdy[1]), .in_data(in_data[1]), .in_last(in_last[1]),
      .out_valid(ov[1]), .out_ready(out_ready[1]), .out_data(b_data), .out_count(b_cnt),
      .out_ovf(ovf[1]), .out_forced(frc[1])
   );

   nn_stream_accum #(.IN_W(18), .OUT_W(24), .MAX_TERMS(4), .SIGNED(1)) u_c (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[2]), .in_ready(rdy[2]), .in_data(in_data[2]), .in_last(in_last[2]),
      .out_valid(ov[2]), .out_ready(out_ready[2]), .out_data(c_data), .out_count(c_cnt),
      .out_ovf(ovf[2]), .out_forced(frc[2])
   );

   assign od[0] = a_data;
   assign od[1] = {4'b0, b_data};
   assign od[2] = c_data;
   assign oc[0] = a_cnt;
   assign oc[1] = b_cnt;
   assign oc[2] = {4'b0, c_cnt};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int id, input logic [23:0] d, input logic [6:0] c,
                       input logic o, input logic f);
      exp_t e;
      e.id = id; e.data = d; e.cnt = c; e.ovf = o; e.forced = f;
      q.push_back(e);
   endtask

   // Drive one beat (called just after a rising edge); returns just after the transfer edge
   task automatic beat(input int i, input logic [17:0] d, input logic l);
      int n = 0;
      in_valid[i] = 1'b1;
      in_data[i]  = d;
      in_last[i]  = l;
      @(negedge clk);
      while (!rdy[i] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("beat_ready", {31'b0, rdy[i]}, 32'd1);
      @(posedge clk);
      #1;
      in_valid[i] = 1'b0;
      in_last[i]  = 1'b0;
      $display("beat dut%0d data=0x%05h last=%0b", i, d, l);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_timeout", q.size(), 32'd0);
   endtask

   // Scoreboard: every result transfer is compared against the oldest expectation
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst && ov[i] && out_ready[i]) begin
            checks++;
            assert (q.size() > 0) else begin
               errors++;
               $error("FAIL unexpected_result: dut%0d data=0x%0h expected none", i, od[i]);
            end
            if (q.size() > 0) begin
               exp_t e;
               e = q.pop_front();
               $display("result dut%0d data=0x%06h count=%0d ovf=%0b forced=%0b",
                        i, od[i], oc[i], ovf[i], frc[i]);
               chk("res_id",     i,                   e.id);
               chk("res_data",   {8'b0, od[i]},       {8'b0, e.data});
               chk("res_count",  {25'b0, oc[i]},      {25'b0, e.cnt});
               chk("res_ovf",    {31'b0, ovf[i]},     {31'b0, e.ovf});
               chk("res_forced", {31'b0, frc[i]},     {31'b0, e.forced});
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b0; in_last[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1;
      end
      @(posedge clk);
      #1;
      // Reset state: every output low
      for (int i = 0; i < 3; i++) begin
         chk("rst_out_valid", {31'b0, ov[i]},  32'd0);
         chk("rst_out_data",  {8'b0, od[i]},   32'd0);
         chk("rst_out_count", {25'b0, oc[i]},  32'd0);
         chk("rst_out_ovf",   {31'b0, ovf[i]}, 32'd0);
         chk("rst_forced",    {31'b0, frc[i]}, 32'd0);
         chk("rst_in_ready",  {31'b0, rdy[i]}, 32'd0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_in_ready", {31'b0, rdy[0]}, 32'd1);

      // Signed mix 100, -30, 7 -> 77, result valid the cycle after the last beat
      push(0, 24'd77, 7'd3, 1'b0, 1'b0);
      beat(0, 18'd100, 1'b0);
      beat(0, 18'h3FFE2, 1'b0);
      beat(0, 18'd7, 1'b1);
      chk("t1_latency", {31'b0, ov[0]}, 32'd1);
      drain();

      // Single most-negative beat from IDLE
      push(0, 24'hFE0000, 7'd1, 1'b0, 1'b0);
      beat(0, 18'h20000, 1'b1);
      drain();

      // Backpressure: result held stable for 5 cycles, no beats accepted
      out_ready[0] = 1'b0;
      push(0, 24'd12, 7'd2, 1'b0, 1'b0);
      beat(0, 18'd5, 1'b0);
      beat(0, 18'd7, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_valid",    {31'b0, ov[0]},  32'd1);
         chk("hold_data",     {8'b0, od[0]},   32'd12);
         chk("hold_in_ready", {31'b0, rdy[0]}, 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("release_valid",    {31'b0, ov[0]},  32'd0);
      chk("release_in_ready", {31'b0, rdy[0]}, 32'd1);
      drain();

      // OUT_W=20: eight beats of 131071 overflow the signed range
`ifdef NN_ACCUM_SATURATE_EN
      push(1, 24'h07FFFF, 7'd8, 1'b1, 1'b0);
`else
      push(1, 24'h0FFFF8, 7'd8, 1'b1, 1'b0);
`endif
      for (int k = 0; k < 8; k++) beat(1, 18'h1FFFF, (k == 7));
      drain();

      // MAX_TERMS=4: forced close after 4 beats, beats 5-6 open the next packet
      push(2, 24'd4, 7'd4, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) beat(2, 18'd1, 1'b0);
      push(2, 24'd3, 7'd3, 1'b0, 1'b0);
      beat(2, 18'd1, 1'b1);
      drain();

      // Reset mid-packet discards the partial sum
      beat(0, 18'd5, 1'b0);
      beat(0, 18'd5, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", {31'b0, ov[0]},  32'd0);
      chk("midrst_out_data",  {8'b0, od[0]},   32'd0);
      chk("midrst_out_count", {25'b0, oc[0]},  32'd0);
      chk("midrst_out_ovf",   {31'b0, ovf[0]}, 32'd0);
      chk("midrst_forced",    {31'b0, frc[0]}, 32'd0);
      chk("midrst_in_ready",  {31'b0, rdy[0]}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      push(0, 24'd3, 7'd1, 1'b0, 1'b0);
      beat(0, 18'd3, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
